result_packer: RTL and testbench

RESULT_PACKER -- requirements
Module: result_packer

---
 rtl/result_packer.sv | 83 ++++++++
 tb/tb_result_packer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/result_packer.sv
// Result packer: tags device results or marker records with a timestamp and buffers them
// ahead of a 64-bit output FIFO that may apply backpressure.
module result_packer #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 24
) (
  input  logic        fpga_clk_i,
  input  logic        reset_i,
  input  logic        timer_tick_i,
  input  logic        ts_clear_i,
  input  logic        data_valid_i,
  input  logic [7:0]  device_i,
  input  logic [31:0] data_i,
  input  logic        marker_i,
  output logic        data_ready_o,
  input  logic        fifo_full_i,
  output logic        fifo_wr_o,
  output logic [63:0] fifo_data_o,
  output logic [15:0] drop_count_o,
  output logic        idle_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [TS_W-1:0] ts;
  logic [15:0]     seq;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [63:0]     mem [DEPTH];
  logic [63:0]     word;
  logic            accept, drop, has_head, pop, bypass, push;

  assign data_ready_o = count < CW'(DEPTH);
  assign accept       = data_valid_i && data_ready_o;
  assign drop         = data_valid_i && !data_ready_o;
  assign has_head     = count != '0;
  assign pop          = has_head && !fifo_full_i;
  // An accepted word arriving at an empty buffer goes straight to the output register,
  // which is what gives the one-cycle accept-to-write latency.
  assign bypass       = !has_head && accept && !fifo_full_i;
  assign push         = accept && !bypass;
  assign idle_o       = !has_head && !fifo_wr_o;

  assign word = marker_i ? {8'hFF, 24'(ts), drop_count_o, seq}
                         : {device_i, 24'(ts), data_i};

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      ts           <= '0;
      seq          <= '0;
      drop_count_o <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      fifo_wr_o    <= 1'b0;
      fifo_data_o  <= '0;
    end else begin
      if (ts_clear_i)        ts <= '0;
      else if (timer_tick_i) ts <= ts + TS_W'(1);

      if (accept && marker_i) seq <= seq + 16'd1;
      if (drop && drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      fifo_wr_o <= pop || bypass;
      if (pop)         fifo_data_o <= mem[rd_ptr];
      else if (bypass) fifo_data_o <= word;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge fpga_clk_i) begin
    if (push) mem[wr_ptr] <= word;
  end
endmodule

// File: tb/tb_result_packer.sv
// Bench for result_packer: vector table, directed corner sequences and randomized traffic
// against a queue-based reference model.
module tb_result_packer;
  logic        clk = 1'b0;
  logic        rst = 1'b0, tick = 1'b0, clr = 1'b0, valid = 1'b0, marker = 1'b0, full = 1'b0;
  logic [7:0]  dev = '0;
  logic [31:0] data = '0;
  logic        ready, wr, idle;
  logic [63:0] fdata;
  logic [15:0] drops;
  logic        ready2, wr2, idle2;
  logic [63:0] fdata2;
  logic [15:0] drops2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  result_packer #(.DEPTH(4), .TS_W(24)) dut (
    .fpga_clk_i(clk), .reset_i(rst), .timer_tick_i(tick), .ts_clear_i(clr),
    .data_valid_i(valid), .device_i(dev), .data_i(data), .marker_i(marker),
    .data_ready_o(ready), .fifo_full_i(full), .fifo_wr_o(wr), .fifo_data_o(fdata),
    .drop_count_o(drops), .idle_o(idle)
  );

  // Narrow timestamp and shallow buffer instance: wrap and depth-2 boundary.
  result_packer #(.DEPTH(2), .TS_W(4)) dut2 (
    .fpga_clk_i(clk), .reset_i(rst), .timer_tick_i(tick), .ts_clear_i(clr),
    .data_valid_i(valid), .device_i(dev), .data_i(data), .marker_i(marker),
    .data_ready_o(ready2), .fifo_full_i(full), .fifo_wr_o(wr2), .fifo_data_o(fdata2),
    .drop_count_o(drops2), .idle_o(idle2)
  );

  // Reference model: buffer contents as a queue of finished words.
  logic [63:0] q[$];
  logic [23:0] m_ts = '0;
  logic [15:0] m_seq = '0, m_drop = '0;
  logic        m_wr = 1'b0;
  logic [63:0] m_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      q.delete();
      m_ts = '0; m_seq = '0; m_drop = '0; m_wr = 1'b0; m_data = '0;
    end else begin
      if (valid) begin
        if (q.size() < 4) begin
          q.push_back(marker ? {8'hFF, m_ts, m_drop, m_seq} : {dev, m_ts, data});
          if (marker) m_seq++;
        end else if (m_drop != 16'hFFFF) m_drop++;
      end
      if (clr) m_ts = '0;
      else if (tick) m_ts++;
      m_wr = 1'b0;
      if (!full && q.size() > 0) begin
        m_data = q.pop_front();
        m_wr = 1'b1;
      end
    end
  endtask

  task automatic model_check();
    chk("model_wr", wr, m_wr);
    chk("model_data", fdata, m_data);
    chk("model_ready", ready, q.size() < 4);
    chk("model_drops", drops, m_drop);
    chk("model_idle", idle, q.size() == 0 && !m_wr);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic set_in(input logic r, input logic t, input logic c, input logic v,
                        input logic m, input logic f, input logic [7:0] d, input logic [31:0] x);
    rst = r; tick = t; clr = c; valid = v; marker = m; full = f; dev = d; data = x;
  endtask

  typedef struct packed {
    logic        rst, tick, clr, valid, marker, full;
    logic [7:0]  dev;
    logic [31:0] data;
    logic        e_wr;
    logic [63:0] e_data;
    logic        e_ready;
    logic [15:0] e_drop;
    logic        e_idle;
  } vec_t;

  function automatic vec_t mk(logic r, logic t, logic c, logic v, logic m, logic f,
                              logic [7:0] d, logic [31:0] x, logic ew, logic [63:0] ed,
                              logic er, logic [15:0] edr, logic ei);
    vec_t o;
    o.rst = r; o.tick = t; o.clr = c; o.valid = v; o.marker = m; o.full = f;
    o.dev = d; o.data = x; o.e_wr = ew; o.e_data = ed; o.e_ready = er;
    o.e_drop = edr; o.e_idle = ei;
    return o;
  endfunction

  vec_t tbl[$];
  int   full_pct;

  initial begin
    // Reset, then five ticks to ts=5, then a single result.
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,32'h0, 0,64'h0,1,16'd0,1));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,1,0,0,0,0,8'h00,32'h0, 0,64'h0,1,16'd0,1));
    tbl.push_back(mk(0,0,0,1,0,0,8'h01,32'hDEADBEEF, 1,64'h01000005DEADBEEF,1,16'd0,0));
    tbl.push_back(mk(0,0,0,0,0,0,8'h00,32'h0, 0,64'h0,1,16'd0,1));
    // Overflow: six valids against a full output FIFO, then drain in order.
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(0,0,0,1,0,1,8'h02,32'hA0 + 32'(i), 0,64'h0, (i < 3), 16'(i < 4 ? 0 : i - 3), 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0,0,0,0,0,0,8'h00,32'h0, 1,{8'h02,24'h000005,32'hA0 + 32'(k)},1,16'd2,0));
    tbl.push_back(mk(0,0,0,0,0,0,8'h00,32'h0, 0,64'h0,1,16'd2,1));
    // Streaming after reset: one write per cycle at one-cycle latency.
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,32'h0, 0,64'h0,1,16'd0,1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0,0,0,1,0,0,8'h03,32'(k + 1), 1,{8'h03,24'h0,32'(k + 1)},1,16'd0,0));
    tbl.push_back(mk(0,0,0,0,0,0,8'h00,32'h0, 0,64'h0,1,16'd0,1));

    foreach (tbl[i]) begin
      set_in(tbl[i].rst, tbl[i].tick, tbl[i].clr, tbl[i].valid, tbl[i].marker, tbl[i].full,
             tbl[i].dev, tbl[i].data);
      cycle();
      chk($sformatf("vec%0d_wr", i), wr, tbl[i].e_wr);
      if (tbl[i].e_wr) chk($sformatf("vec%0d_data", i), fdata, tbl[i].e_data);
      chk($sformatf("vec%0d_ready", i), ready, tbl[i].e_ready);
      chk($sformatf("vec%0d_drop", i), drops, tbl[i].e_drop);
      chk($sformatf("vec%0d_idle", i), idle, tbl[i].e_idle);
    end

    // Marker: ts=0x10, three drops, drain, then two markers.
    set_in(1,0,0,0,0,0,0,0); cycle();
    for (int i = 0; i < 16; i++) begin set_in(0,1,0,0,0,0,0,0); cycle(); end
    for (int i = 0; i < 7; i++) begin set_in(0,0,0,1,0,1,8'h04,32'(i)); cycle(); end
    chk("marker_drops", drops, 16'd3);
    for (int i = 0; i < 5; i++) begin set_in(0,0,0,0,0,0,0,0); cycle(); end
    set_in(0,0,0,1,1,0,0,0); cycle();
    chk("marker0_wr", wr, 1'b1);
    chk("marker0_word", fdata, 64'hFF00001000030000);
    cycle();
    chk("marker1_word", fdata, 64'hFF00001000030001);

    // Clear wins over a simultaneous tick.
    set_in(1,0,0,0,0,0,0,0); cycle();
    for (int i = 0; i < 3; i++) begin set_in(0,1,0,0,0,0,0,0); cycle(); end
    set_in(0,1,1,0,0,0,0,0); cycle();
    set_in(0,0,0,1,0,0,8'h06,32'h3); cycle();
    chk("clr_tick_word", fdata, 64'h0600000000000003);

    // Wrap on the 4-bit instance: capture pre-tick value, then the wrapped zero.
    set_in(1,0,0,0,0,0,0,0); cycle();
    for (int i = 0; i < 15; i++) begin set_in(0,1,0,0,0,0,0,0); cycle(); end
    set_in(0,1,0,1,0,0,8'h05,32'h1); cycle();
    chk("wrap_pre_wr", wr2, 1'b1);
    chk("wrap_pre_word", fdata2, 64'h0500000F00000001);
    set_in(0,0,0,1,0,0,8'h05,32'h2); cycle();
    chk("wrap_post_word", fdata2, 64'h0500000000000002);
    set_in(0,0,0,1,0,1,8'h05,32'h3); cycle();
    chk("d2_ready_1", ready2, 1'b1);
    cycle();
    chk("d2_ready_0", ready2, 1'b0);
    cycle();
    chk("d2_drop", drops2, 16'd1);

    // Reset mid-burst with valid held high: buffered words vanish, nothing counted.
    set_in(1,0,0,0,0,0,0,0); cycle();
    for (int i = 0; i < 5; i++) begin set_in(0,0,0,1,0,1,8'h07,32'(i)); cycle(); end
    chk("burst_drop_before", drops, 16'd1);
    set_in(1,0,0,1,0,1,8'h07,32'h9); cycle();
    for (int i = 0; i < 3; i++) begin
      set_in(0,0,0,0,0,0,0,0); cycle();
      chk($sformatf("burst_nowr%0d", i), wr, 1'b0);
      chk($sformatf("burst_idle%0d", i), idle, 1'b1);
      chk($sformatf("burst_drop%0d", i), drops, 16'd0);
    end

    // Randomized traffic with varying backpressure.
    full_pct = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) begin
        case ($urandom_range(0, 3))
          0: full_pct = 0;
          1: full_pct = 30;
          2: full_pct = 70;
          default: full_pct = 95;
        endcase
      end
      set_in($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 99) < full_pct, 8'($urandom), $urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
